// File: rtl/canvas_write_arbiter.sv
// canvas_write_arbiter: framebuffer write port shared by a clear sweep,
// a pen requester and an overlay requester (round-robin between the two).
module canvas_write_arbiter #(
  parameter int unsigned SCREEN_WIDTH  = 320,
  parameter int unsigned SCREEN_HEIGHT = 240,
  parameter logic [8:0]  CLEAR_COLOR   = 9'b111_111_111
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       clear_req,
  input  logic       pen_req,
  input  logic [8:0] pen_x,
  input  logic [7:0] pen_y,
  input  logic [8:0] pen_color,
  output logic       pen_ack,
  input  logic       ovl_req,
  input  logic [8:0] ovl_x,
  input  logic [7:0] ovl_y,
  input  logic [8:0] ovl_color,
  output logic       ovl_ack,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [8:0] vga_color,
  output logic       vga_write,
  output logic       clearing,
  output logic [7:0] drop_count
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_ARB   = 1'b1
  } state_t;

  localparam logic [8:0] LAST_X = 9'(SCREEN_WIDTH - 1);
  localparam logic [7:0] LAST_Y = 8'(SCREEN_HEIGHT - 1);
  localparam logic [9:0] X_LIM  = 10'(SCREEN_WIDTH);
  localparam logic [8:0] Y_LIM  = 9'(SCREEN_HEIGHT);

  state_t     r_state;
  logic [8:0] r_cx;
  logic [7:0] r_cy;
  logic [8:0] r_vga_x;
  logic [7:0] r_vga_y;
  logic [8:0] r_vga_color;
  logic       r_vga_write;
  logic       r_pen_ack;
  logic       r_ovl_ack;
  logic [7:0] r_drop;
  logic       r_last_ovl;

  state_t     w_state_nxt;
  logic [8:0] w_cx_nxt;
  logic [7:0] w_cy_nxt;
  logic [8:0] w_x_nxt;
  logic [7:0] w_y_nxt;
  logic [8:0] w_c_nxt;
  logic       w_wr_nxt;
  logic       w_pack_nxt;
  logic       w_oack_nxt;
  logic [7:0] w_drop_nxt;
  logic       w_last_ovl_nxt;

  logic       w_pen_ok;
  logic       w_ovl_ok;
  logic       w_gnt_pen;
  logic       w_gnt_ovl;
  logic [8:0] w_sel_x;
  logic [7:0] w_sel_y;
  logic [8:0] w_sel_c;
  logic       w_oob;

  // A requester that is being acked this cycle sits out one arbitration.
  assign w_pen_ok  = pen_req && !r_pen_ack;
  assign w_ovl_ok  = ovl_req && !r_ovl_ack;
  assign w_gnt_pen = w_pen_ok && (!w_ovl_ok || r_last_ovl);
  assign w_gnt_ovl = w_ovl_ok && !w_gnt_pen;

  assign w_sel_x = w_gnt_pen ? pen_x : ovl_x;
  assign w_sel_y = w_gnt_pen ? pen_y : ovl_y;
  assign w_sel_c = w_gnt_pen ? pen_color : ovl_color;
  assign w_oob   = ({1'b0, w_sel_x} >= X_LIM) ||
                   ({1'b0, w_sel_y} >= Y_LIM);

  // Next state and registered outputs; clear_req overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_cx_nxt       = r_cx;
    w_cy_nxt       = r_cy;
    w_x_nxt        = r_vga_x;
    w_y_nxt        = r_vga_y;
    w_c_nxt        = r_vga_color;
    w_wr_nxt       = 1'b0;
    w_pack_nxt     = 1'b0;
    w_oack_nxt     = 1'b0;
    w_drop_nxt     = r_drop;
    w_last_ovl_nxt = r_last_ovl;
    if (clear_req) begin
      w_state_nxt = S_CLEAR;
      w_cx_nxt    = 9'd0;
      w_cy_nxt    = 8'd0;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          w_x_nxt  = r_cx;
          w_y_nxt  = r_cy;
          w_c_nxt  = CLEAR_COLOR;
          w_wr_nxt = 1'b1;
          if (r_cx == LAST_X) begin
            w_cx_nxt = 9'd0;
            if (r_cy == LAST_Y) begin
              w_cy_nxt    = 8'd0;
              w_state_nxt = S_ARB;
            end else begin
              w_cy_nxt = r_cy + 8'd1;
            end
          end else begin
            w_cx_nxt = r_cx + 9'd1;
          end
        end
        S_ARB: begin
          if (w_gnt_pen || w_gnt_ovl) begin
            w_x_nxt        = w_sel_x;
            w_y_nxt        = w_sel_y;
            w_c_nxt        = w_sel_c;
            w_pack_nxt     = w_gnt_pen;
            w_oack_nxt     = w_gnt_ovl;
            w_last_ovl_nxt = w_gnt_ovl;
            if (w_oob) begin
              if (r_drop != 8'hFF) begin
                w_drop_nxt = r_drop + 8'd1;
              end
            end else begin
              w_wr_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_CLEAR;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_cx        <= 9'd0;
      r_cy        <= 8'd0;
      r_vga_x     <= 9'd0;
      r_vga_y     <= 8'd0;
      r_vga_color <= CLEAR_COLOR;
      r_vga_write <= 1'b0;
      r_pen_ack   <= 1'b0;
      r_ovl_ack   <= 1'b0;
      r_drop      <= 8'd0;
      r_last_ovl  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cx        <= w_cx_nxt;
      r_cy        <= w_cy_nxt;
      r_vga_x     <= w_x_nxt;
      r_vga_y     <= w_y_nxt;
      r_vga_color <= w_c_nxt;
      r_vga_write <= w_wr_nxt;
      r_pen_ack   <= w_pack_nxt;
      r_ovl_ack   <= w_oack_nxt;
      r_drop      <= w_drop_nxt;
      r_last_ovl  <= w_last_ovl_nxt;
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_color  = r_vga_color;
  assign vga_write  = r_vga_write;
  assign pen_ack    = r_pen_ack;
  assign ovl_ack    = r_ovl_ack;
  assign clearing   = (r_state == S_CLEAR);
  assign drop_count = r_drop;

endmodule
